// File: rtl/input_debouncer_pkg.sv
// rtl/input_debouncer_pkg.sv - shared types and defaults for the input debouncer
package input_debouncer_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW     = 2'd0,
    CONFIRM_HIGH = 2'd1,
    IDLE_HIGH    = 2'd2,
    CONFIRM_LOW  = 2'd3
  } db_state_e;

  localparam int unsigned DB_CYCLES_DEF   = 16;
  localparam int unsigned SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one channel: synchronizer, confirm FSM and edge pulses
module debounce_channel
  import input_debouncer_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned DB_CYCLES   = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic raw_in,
  output logic clean_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  db_state_e              state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   clean_q, clean_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  // Synchronizer keeps running regardless of ena so the FSM never sees stale data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
      clean_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (ena) begin
      case (state_q)
        IDLE_LOW: begin
          if (sync) begin
            if (DB_CYCLES == 1) begin
              state_d = IDLE_HIGH;
            end else begin
              state_d = CONFIRM_HIGH;
              cnt_d   = CNT_ONE;
            end
          end
        end
        CONFIRM_HIGH: begin
          if (!sync) begin
            state_d = IDLE_LOW;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = IDLE_HIGH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        IDLE_HIGH: begin
          if (!sync) begin
            if (DB_CYCLES == 1) begin
              state_d = IDLE_LOW;
            end else begin
              state_d = CONFIRM_LOW;
              cnt_d   = CNT_ONE;
            end
          end
        end
        CONFIRM_LOW: begin
          if (sync) begin
            state_d = IDLE_HIGH;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = IDLE_LOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Level and pulses are registered together so a pulse lines up with the new level.
  always_comb begin
    clean_d = clean_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (ena) begin
      clean_d = (state_q == IDLE_HIGH) || (state_q == CONFIRM_LOW);
      rise_d  = clean_d & ~clean_q;
      fall_d  = ~clean_d & clean_q;
    end
  end

  assign clean_o = clean_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/input_debouncer.sv
// rtl/input_debouncer.sv - multi-channel input debouncer; DEBOUNCE_EDGE_CNT_EN adds a rise-event counter
module input_debouncer
  import input_debouncer_pkg::*;
#(
  parameter int unsigned N_CH        = 2,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned DB_CYCLES   = DB_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ena,
  input  logic [N_CH-1:0] raw_in,
  output logic [N_CH-1:0] clean_o,
  output logic [N_CH-1:0] rise_o,
  output logic [N_CH-1:0] fall_o,
  output logic [7:0]      edge_cnt_o
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES(SYNC_STAGES),
      .DB_CYCLES  (DB_CYCLES)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .ena    (ena),
      .raw_in (raw_in[i]),
      .clean_o(clean_o[i]),
      .rise_o (rise_o[i]),
      .fall_o (fall_o[i])
    );
  end

`ifdef DEBOUNCE_EDGE_CNT_EN
  logic [7:0] edge_cnt_q, edge_cnt_d;

  // Simultaneous rises on several channels count as a single event.
  assign edge_cnt_d = edge_cnt_q + {7'd0, |rise_o};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt_q <= 8'd0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
    end
  end

  assign edge_cnt_o = edge_cnt_q;
`else
  assign edge_cnt_o = 8'd0;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// tb/tb_input_debouncer.sv - directed self-checking bench for input_debouncer (N_CH=2, DB_CYCLES=4)
module tb_input_debouncer;

`ifdef DEBOUNCE_EDGE_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [1:0] raw_in;
  logic [1:0] clean_o, rise_o, fall_o;
  logic [7:0] edge_cnt_o;

  int         n_checks = 0;
  int         n_fails  = 0;
  logic [7:0] exp_cnt  = 8'd0;

  input_debouncer #(
    .N_CH       (2),
    .SYNC_STAGES(2),
    .DB_CYCLES  (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .raw_in    (raw_in),
    .clean_o   (clean_o),
    .rise_o    (rise_o),
    .fall_o    (fall_o),
    .edge_cnt_o(edge_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic count_rise();
    if (CNT_EN) exp_cnt = exp_cnt + 8'd1;
  endtask

  task automatic test_reset();
    n_checks++;
    if ({clean_o, rise_o, fall_o, edge_cnt_o} !== 14'd0) begin
      $display("FAIL reset_state: got %h expected 0", {clean_o, rise_o, fall_o, edge_cnt_o});
      n_fails++;
    end
    raw_in = 2'b11;
    tick(8);
    count_rise();
    n_checks++;
    if (clean_o !== 2'b11) begin
      $display("FAIL pre_reset_clean: got %b expected 11", clean_o);
      n_fails++;
    end
    n_checks++;
    if (edge_cnt_o !== exp_cnt) begin
      $display("FAIL pre_reset_cnt: got %0d expected %0d", edge_cnt_o, exp_cnt);
      n_fails++;
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    exp_cnt = 8'd0;
    n_checks++;
    if ({clean_o, rise_o, fall_o, edge_cnt_o} !== 14'd0) begin
      $display("FAIL async_reset: got %h expected 0", {clean_o, rise_o, fall_o, edge_cnt_o});
      n_fails++;
    end
    for (int k = 0; k < 3; k++) begin
      tick(1);
      n_checks++;
      if ({clean_o, rise_o, fall_o, edge_cnt_o} !== 14'd0) begin
        $display("FAIL reset_hold[%0d]: got %h expected 0", k, {clean_o, rise_o, fall_o, edge_cnt_o});
        n_fails++;
      end
    end
    raw_in = 2'b00;
    rst_n  = 1'b1;
    tick(4);
  endtask

  task automatic test_clean_rise();
    raw_in[0] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      n_checks++;
      if (clean_o[0] !== (k >= 6) || rise_o[0] !== (k == 6) || fall_o[0] !== 1'b0) begin
        $display("FAIL clean_rise[edge %0d]: got clean=%b rise=%b fall=%b expected clean=%b rise=%b fall=0",
                 k, clean_o[0], rise_o[0], fall_o[0], (k >= 6), (k == 6));
        n_fails++;
      end
    end
    count_rise();
    raw_in[0] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      n_checks++;
      if (clean_o[0] !== (k < 6) || fall_o[0] !== (k == 6) || rise_o[0] !== 1'b0) begin
        $display("FAIL clean_fall[edge %0d]: got clean=%b fall=%b rise=%b expected clean=%b fall=%b rise=0",
                 k, clean_o[0], fall_o[0], rise_o[0], (k < 6), (k == 6));
        n_fails++;
      end
    end
    tick(2);
  endtask

  task automatic test_glitch();
    for (int k = 0; k < 15; k++) begin
      raw_in[1] = (k < 3);
      tick(1);
      n_checks++;
      if (clean_o[1] !== 1'b0 || rise_o[1] !== 1'b0 || fall_o[1] !== 1'b0) begin
        $display("FAIL glitch[%0d]: got clean=%b rise=%b fall=%b expected all 0",
                 k, clean_o[1], rise_o[1], fall_o[1]);
        n_fails++;
      end
    end
  endtask

  task automatic test_bounce();
    logic [3:0] pat;
    int         n_rise;
    pat    = 4'b0101;
    n_rise = 0;
    for (int k = 0; k < 4; k++) begin
      raw_in[1] = pat[k];
      tick(1);
      n_rise += int'(rise_o[1]);
    end
    raw_in[1] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      n_rise += int'(rise_o[1]);
      n_checks++;
      if (clean_o[1] !== (k >= 6) || rise_o[1] !== (k == 6)) begin
        $display("FAIL bounce[edge %0d]: got clean=%b rise=%b expected clean=%b rise=%b",
                 k, clean_o[1], rise_o[1], (k >= 6), (k == 6));
        n_fails++;
      end
    end
    count_rise();
    n_checks++;
    if (n_rise != 1) begin
      $display("FAIL bounce_rise_count: got %0d expected 1", n_rise);
      n_fails++;
    end
    raw_in[1] = 1'b0;
    tick(10);
  endtask

  task automatic test_ena_freeze();
    raw_in[0] = 1'b1;
    for (int k = 0; k < 13; k++) begin
      tick(1);
      n_checks++;
      if (clean_o[0] !== (k >= 11) || rise_o[0] !== (k == 11)) begin
        $display("FAIL ena_freeze[edge %0d]: got clean=%b rise=%b expected clean=%b rise=%b",
                 k, clean_o[0], rise_o[0], (k >= 11), (k == 11));
        n_fails++;
      end
      if (k == 3) ena = 1'b0;
      if (k == 8) ena = 1'b1;
    end
    count_rise();
    raw_in[0] = 1'b0;
    tick(10);
  endtask

  task automatic test_edge_cnt();
    rst_n = 1'b0;
    tick(1);
    rst_n   = 1'b1;
    exp_cnt = 8'd0;
    n_checks++;
    if (edge_cnt_o !== 8'd0) begin
      $display("FAIL cnt_after_reset: got %0d expected 0", edge_cnt_o);
      n_fails++;
    end
    raw_in = 2'b11;
    tick(7);
    n_checks++;
    if (rise_o !== 2'b11 || clean_o !== 2'b11) begin
      $display("FAIL simul_rise: got rise=%b clean=%b expected rise=11 clean=11", rise_o, clean_o);
      n_fails++;
    end
    tick(1);
    count_rise();
    n_checks++;
    if (edge_cnt_o !== exp_cnt) begin
      $display("FAIL simul_cnt: got %0d expected %0d", edge_cnt_o, exp_cnt);
      n_fails++;
    end
    raw_in = 2'b00;
    tick(10);
    for (int j = 0; j < 256; j++) begin
      raw_in = 2'b01;
      tick(8);
      count_rise();
      raw_in = 2'b00;
      tick(8);
      n_checks++;
      if (edge_cnt_o !== exp_cnt) begin
        $display("FAIL cnt_event[%0d]: got %0d expected %0d", j, edge_cnt_o, exp_cnt);
        n_fails++;
      end
    end
    n_checks++;
    if (edge_cnt_o !== (CNT_EN ? 8'd1 : 8'd0)) begin
      $display("FAIL cnt_wrap: got %0d expected %0d", edge_cnt_o, (CNT_EN ? 1 : 0));
      n_fails++;
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    raw_in = 2'b00;
    tick(2);
    rst_n = 1'b1;
    test_reset();
    test_clean_rise();
    test_glitch();
    test_bounce();
    test_ena_freeze();
    test_edge_cnt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
